elink_in_frame_assembler: RTL and testbench

ELINK_IN_FRAME_ASSEMBLER -- requirements
Module: elink_in_frame_assembler

---
 rtl/elink_in_frame_assembler_pkg.sv | 53 +++++
 rtl/elink_in_fwft_fifo.sv | 84 ++++++++
 rtl/elink_in_frame_assembler.sv | 250 +++++++++++++++++++++++++
 tb/tb_elink_in_frame_assembler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elink_in_frame_assembler_pkg.sv
// ---------------------------------------------------------------------------
// elink_in_frame_assembler_pkg
//
// Purpose: definitions shared by the E-link input frame assembler and its
// output FIFO.
//   - ISK character-class encodings produced by the 8b10b decoder
//   - FSM state encoding of the assembler
//   - layout of one output FIFO entry, packed as {err, last, first, byte}
//   - small helper functions used at elaboration and in the datapath
// ---------------------------------------------------------------------------
package elink_in_frame_assembler_pkg;

  // Character class presented on ISK alongside every decoded byte.
  localparam logic [1:0] ISK_DATA  = 2'b00;
  localparam logic [1:0] ISK_SOP   = 2'b10;
  localparam logic [1:0] ISK_EOP   = 2'b01;
  localparam logic [1:0] ISK_COMMA = 2'b11;

  // Assembler FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // One FIFO entry: error flag, last flag, first flag, data byte.
  localparam int ENTRY_W = 11;

  typedef struct packed {
    logic       err;
    logic       last;
    logic       first;
    logic [7:0] data;
  } frame_entry_t;

  // Builds an entry from its fields so callers never depend on bit order.
  function automatic frame_entry_t makeEntry(input logic       err,
                                             input logic       last,
                                             input logic       first,
                                             input logic [7:0] data);
    frame_entry_t e;
    e.err   = err;
    e.last  = last;
    e.first = first;
    e.data  = data;
    return e;
  endfunction

  // Pointer width for a power-of-two FIFO: address bits plus one wrap bit,
  // so full and empty can be told apart when the addresses match.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/elink_in_fwft_fifo.sv
// ---------------------------------------------------------------------------
// elink_in_fwft_fifo
//
// Purpose: generic first-word-fall-through FIFO. The head entry is visible on
// rd_data_o whenever empty_o is low; asserting rd_en_i pops it at the next
// clock edge.
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries, power of two
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset, empties the FIFO
//   wr_en_i    push wr_data_i (ignored while full)
//   wr_data_i  entry to push
//   full_o     no free entry; reflects state before any pop this cycle
//   rd_en_i    pop the head entry (ignored while empty)
//   rd_data_o  head entry, forced to zero while empty
//   empty_o    no entry stored
// ---------------------------------------------------------------------------
module elink_in_fwft_fifo
  import elink_in_frame_assembler_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doWrite;
  logic             doRead;

  // Matching addresses mean empty when the wrap bits agree and full when they
  // differ. Full is taken from the registered pointers, so a pop in the same
  // cycle never makes room for a push.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  assign doWrite = wr_en_i && !full_o;
  assign doRead  = rd_en_i && !empty_o;

  // The head is gated to zero while empty so downstream sees clean outputs
  // out of reset and between frames.
  assign rd_data_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  // Pointer bookkeeping; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doWrite) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (doRead) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
    end
  end

  // Storage array; contents are only observable through valid pointers, so
  // it needs no reset.
  always_ff @(posedge clk_i) begin
    if (doWrite) begin
      mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/elink_in_frame_assembler.sv
// ---------------------------------------------------------------------------
// elink_in_frame_assembler
//
// Purpose: turns the stream of decoded E-link characters (SOP, data, EOP,
// comma) into framed bytes in an output FWFT FIFO. Each byte is kept in a
// one-byte hold register until the next character shows whether it is the
// last byte of its frame, so first/last/err flags travel with the data.
// Truncated frames (restart, length overflow, FIFO overflow) are closed with
// last=1, err=1.
//
// Parameters:
//   FIFO_DEPTH  output FIFO entries, power of two, 4..256
//   MAX_LEN     maximum data bytes per frame, 1..255
//
// Ports:
//   bitCLKx4     clock (decoder character clock)
//   rst_n        asynchronous active-low reset
//   DATA_RDY     strobe: HGFEDCBA/ISK hold a decoded character
//   HGFEDCBA     decoded byte
//   ISK          character class: 00 data, 10 SOP, 01 EOP, 11 comma
//   frame_data   byte at FIFO head
//   frame_first  head byte opens a frame
//   frame_last   head byte closes a frame
//   frame_err    head frame was truncated (meaningful with frame_last)
//   frame_valid  FIFO head is valid
//   frame_ready  consumer takes the head when frame_valid is also high
//   frame_cnt    cleanly closed frames written, wrapping
//   err_cnt      error events, saturating at 255
// ---------------------------------------------------------------------------
module elink_in_frame_assembler
  import elink_in_frame_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = 64
) (
  input  logic        bitCLKx4,
  input  logic        rst_n,
  input  logic        DATA_RDY,
  input  logic [7:0]  HGFEDCBA,
  input  logic [1:0]  ISK,
  output logic [7:0]  frame_data,
  output logic        frame_first,
  output logic        frame_last,
  output logic        frame_err,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic        holdValid_q, holdValid_d;
  logic        holdPend_q, holdPend_d;
  logic        holdFirst_q, holdFirst_d;
  logic [7:0]  holdByte_q, holdByte_d;
  logic [15:0] frameCnt_q;
  logic [7:0]  errCnt_q;

  logic               charValid;
  logic               holdBusy;
  logic               wrEn;
  frame_entry_t       wrEntry;
  logic               errInc;
  logic               frameInc;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] headBits;
  frame_entry_t       headEntry;

  // Commas and cycles without a strobe are invisible to the FSM.
  assign charValid = DATA_RDY && (ISK != ISK_COMMA);

  // A held byte already closed with last+err that cannot be written this
  // cycle; it blocks the start of a new frame until the FIFO drains.
  assign holdBusy = holdPend_q && fifoFull;

  // Next-state logic. A pending (already closed) held byte is flushed first
  // whenever the FIFO has room; that flush and every frame decision share a
  // single write port, which is safe because a pending byte only exists
  // outside DATA and writes from the character path only happen inside DATA.
  // Any write the frame needs while the FIFO is full turns into a truncation:
  // the held byte is marked pending and the FSM drops the rest of the frame.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    holdValid_d = holdValid_q;
    holdPend_d  = holdPend_q;
    holdFirst_d = holdFirst_q;
    holdByte_d  = holdByte_q;
    wrEn        = 1'b0;
    wrEntry     = '0;
    errInc      = 1'b0;
    frameInc    = 1'b0;

    if (holdPend_q && !fifoFull) begin
      wrEn        = 1'b1;
      wrEntry     = makeEntry(1'b1, 1'b1, holdFirst_q, holdByte_q);
      holdValid_d = 1'b0;
      holdPend_d  = 1'b0;
    end

    if (charValid) begin
      case (state_q)
        ST_IDLE: begin
          if (ISK == ISK_SOP) begin
            if (!holdBusy) begin
              state_d = ST_DATA;
              len_d   = '0;
            end
          end else begin
            errInc = 1'b1;
          end
        end

        ST_DATA: begin
          if (ISK == ISK_DATA) begin
            if (len_q == MAX_LEN_B) begin
              errInc  = 1'b1;
              state_d = ST_DROP;
              if (fifoFull) begin
                holdPend_d = 1'b1;
              end else begin
                wrEn        = 1'b1;
                wrEntry     = makeEntry(1'b1, 1'b1, holdFirst_q, holdByte_q);
                holdValid_d = 1'b0;
              end
            end else if (holdValid_q && fifoFull) begin
              errInc     = 1'b1;
              holdPend_d = 1'b1;
              state_d    = ST_DROP;
            end else begin
              if (holdValid_q) begin
                wrEn    = 1'b1;
                wrEntry = makeEntry(1'b0, 1'b0, holdFirst_q, holdByte_q);
              end
              holdValid_d = 1'b1;
              holdByte_d  = HGFEDCBA;
              holdFirst_d = (len_q == 8'd0);
              len_d       = len_q + 8'd1;
            end
          end else if (ISK == ISK_EOP) begin
            len_d = '0;
            if (!holdValid_q) begin
              errInc  = 1'b1;
              state_d = ST_IDLE;
            end else if (fifoFull) begin
              errInc     = 1'b1;
              holdPend_d = 1'b1;
              state_d    = ST_DROP;
            end else begin
              wrEn        = 1'b1;
              wrEntry     = makeEntry(1'b0, 1'b1, holdFirst_q, holdByte_q);
              frameInc    = 1'b1;
              holdValid_d = 1'b0;
              state_d     = ST_IDLE;
            end
          end else begin
            // SOP inside a frame: close the open one as truncated and restart.
            len_d = '0;
            if (holdValid_q) begin
              errInc = 1'b1;
              if (fifoFull) begin
                holdPend_d = 1'b1;
                state_d    = ST_DROP;
              end else begin
                wrEn        = 1'b1;
                wrEntry     = makeEntry(1'b1, 1'b1, holdFirst_q, holdByte_q);
                holdValid_d = 1'b0;
              end
            end
          end
        end

        ST_DROP: begin
          if (ISK == ISK_SOP) begin
            len_d   = '0;
            state_d = holdBusy ? ST_IDLE : ST_DATA;
          end else if (ISK == ISK_EOP) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, length and hold register state.
  always_ff @(posedge bitCLKx4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      holdValid_q <= 1'b0;
      holdPend_q  <= 1'b0;
      holdFirst_q <= 1'b0;
      holdByte_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      holdValid_q <= holdValid_d;
      holdPend_q  <= holdPend_d;
      holdFirst_q <= holdFirst_d;
      holdByte_q  <= holdByte_d;
    end
  end

  // Statistics: clean frames wrap naturally, errors stick at the top.
  always_ff @(posedge bitCLKx4 or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt_q <= '0;
      errCnt_q   <= '0;
    end else begin
      if (frameInc) begin
        frameCnt_q <= frameCnt_q + 16'd1;
      end
      if (errInc && (errCnt_q != 8'hFF)) begin
        errCnt_q <= errCnt_q + 8'd1;
      end
    end
  end

  elink_in_fwft_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (bitCLKx4),
    .rst_ni    (rst_n),
    .wr_en_i   (wrEn),
    .wr_data_i (wrEntry),
    .full_o    (fifoFull),
    .rd_en_i   (frame_ready),
    .rd_data_o (headBits),
    .empty_o   (fifoEmpty)
  );

  assign headEntry   = frame_entry_t'(headBits);
  assign frame_valid = !fifoEmpty;
  assign frame_data  = headEntry.data;
  assign frame_first = headEntry.first;
  assign frame_last  = headEntry.last;
  assign frame_err   = headEntry.err;
  assign frame_cnt   = frameCnt_q;
  assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_elink_in_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_elink_in_frame_assembler
//
// Two assembler instances share one character stream: dutMain has a 4-entry
// FIFO (overflow behaviour), dutShort has MAX_LEN=4 (length limit). Each
// scenario task pushes expected entries {err,last,first,byte} into a queue
// as it drives characters; a negedge monitor records every accepted head
// entry, and the task compares both queues in order afterwards.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elink_in_frame_assembler;

  localparam logic [1:0] K_DATA  = 2'b00;
  localparam logic [1:0] K_SOP   = 2'b10;
  localparam logic [1:0] K_EOP   = 2'b01;
  localparam logic [1:0] K_COMMA = 2'b11;

  logic       bitCLKx4 = 1'b0;
  logic       rst_n;
  logic       DATA_RDY;
  logic [7:0] HGFEDCBA;
  logic [1:0] ISK;
  logic       frame_ready;
  logic       randReady;

  logic [7:0]  mainData, shortData;
  logic        mainFirst, mainLast, mainErr, mainValid;
  logic        shortFirst, shortLast, shortErr, shortValid;
  logic [15:0] mainFrameCnt, shortFrameCnt;
  logic [7:0]  mainErrCnt, shortErrCnt;

  logic [10:0] expMain[$];
  logic [10:0] obsMain[$];
  logic [10:0] expShort[$];
  logic [10:0] obsShort[$];

  int checks = 0;
  int fails  = 0;

  always #5 bitCLKx4 = ~bitCLKx4;

  elink_in_frame_assembler #(.FIFO_DEPTH(4), .MAX_LEN(64)) dutMain (
    .bitCLKx4    (bitCLKx4),
    .rst_n       (rst_n),
    .DATA_RDY    (DATA_RDY),
    .HGFEDCBA    (HGFEDCBA),
    .ISK         (ISK),
    .frame_data  (mainData),
    .frame_first (mainFirst),
    .frame_last  (mainLast),
    .frame_err   (mainErr),
    .frame_valid (mainValid),
    .frame_ready (frame_ready),
    .frame_cnt   (mainFrameCnt),
    .err_cnt     (mainErrCnt)
  );

  elink_in_frame_assembler #(.FIFO_DEPTH(16), .MAX_LEN(4)) dutShort (
    .bitCLKx4    (bitCLKx4),
    .rst_n       (rst_n),
    .DATA_RDY    (DATA_RDY),
    .HGFEDCBA    (HGFEDCBA),
    .ISK         (ISK),
    .frame_data  (shortData),
    .frame_first (shortFirst),
    .frame_last  (shortLast),
    .frame_err   (shortErr),
    .frame_valid (shortValid),
    .frame_ready (frame_ready),
    .frame_cnt   (shortFrameCnt),
    .err_cnt     (shortErrCnt)
  );

  // Record every head entry the consumer takes, sampled mid-cycle.
  always @(negedge bitCLKx4) begin
    if (mainValid && frame_ready) obsMain.push_back({mainErr, mainLast, mainFirst, mainData});
    if (shortValid && frame_ready) obsShort.push_back({shortErr, shortLast, shortFirst, shortData});
  end

  // Optional random backpressure, driven away from the task drive point.
  always @(posedge bitCLKx4) begin
    #2;
    if (randReady) frame_ready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge bitCLKx4);
      #1;
    end
  endtask

  task automatic sendChar(input logic [1:0] k, input logic [7:0] b);
    DATA_RDY = 1'b1;
    ISK      = k;
    HGFEDCBA = b;
    @(posedge bitCLKx4);
    #1;
    DATA_RDY = 1'b0;
    ISK      = K_COMMA;
    HGFEDCBA = 8'h00;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    expMain.delete();
    obsMain.delete();
    expShort.delete();
    obsShort.delete();
  endtask

  task automatic test_reset();
    logic [10:0] e, o;
    rst_n = 1'b0;
    idle(3);
    checks++; if (mainValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", mainValid); end
    checks++; if (mainData !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", mainData); end
    checks++; if ({mainFirst, mainLast, mainErr} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {mainFirst, mainLast, mainErr}); end
    checks++; if (mainFrameCnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", mainFrameCnt); end
    checks++; if (mainErrCnt !== 8'd0) begin fails++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", mainErrCnt); end
    checks++; if (shortValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_short_valid: got %b expected 0", shortValid); end
    rst_n = 1'b1;
    idle(2);
    checks++; if (mainValid !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_valid: got %b expected 0", mainValid); end
  endtask

  task automatic test_basic_frame();
    logic [10:0] e, o;
    applyReset();
    frame_ready = 1'b1;
    sendChar(K_SOP, 8'h00);
    expMain.push_back({1'b0, 1'b0, 1'b1, 8'h11}); sendChar(K_DATA, 8'h11);
    expMain.push_back({1'b0, 1'b0, 1'b0, 8'h22}); sendChar(K_DATA, 8'h22);
    expMain.push_back({1'b0, 1'b1, 1'b0, 8'h33}); sendChar(K_DATA, 8'h33);
    sendChar(K_EOP, 8'h00);
    idle(6);
    checks++; if (obsMain.size() != expMain.size()) begin fails++; $display("[TB] FAIL basic_count: got %0d expected %0d", obsMain.size(), expMain.size()); end
    while (expMain.size() > 0 && obsMain.size() > 0) begin
      e = expMain.pop_front(); o = obsMain.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL basic_entry: got %h expected %h", o, e); end
    end
    checks++; if (mainFrameCnt !== 16'd1) begin fails++; $display("[TB] FAIL basic_frame_cnt: got %0d expected 1", mainFrameCnt); end
    checks++; if (mainErrCnt !== 8'd0) begin fails++; $display("[TB] FAIL basic_err_cnt: got %0d expected 0", mainErrCnt); end
  endtask

  task automatic test_sop_abort();
    logic [10:0] e, o;
    applyReset();
    frame_ready = 1'b1;
    sendChar(K_SOP, 8'h00);
    expMain.push_back({1'b1, 1'b1, 1'b1, 8'hAA}); sendChar(K_DATA, 8'hAA);
    sendChar(K_SOP, 8'h00);
    expMain.push_back({1'b0, 1'b1, 1'b1, 8'hBB}); sendChar(K_DATA, 8'hBB);
    sendChar(K_EOP, 8'h00);
    idle(6);
    checks++; if (obsMain.size() != expMain.size()) begin fails++; $display("[TB] FAIL abort_count: got %0d expected %0d", obsMain.size(), expMain.size()); end
    while (expMain.size() > 0 && obsMain.size() > 0) begin
      e = expMain.pop_front(); o = obsMain.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL abort_entry: got %h expected %h", o, e); end
    end
    checks++; if (mainErrCnt !== 8'd1) begin fails++; $display("[TB] FAIL abort_err_cnt: got %0d expected 1", mainErrCnt); end
    checks++; if (mainFrameCnt !== 16'd1) begin fails++; $display("[TB] FAIL abort_frame_cnt: got %0d expected 1", mainFrameCnt); end
  endtask

  task automatic test_max_len();
    logic [10:0] e, o;
    applyReset();
    frame_ready = 1'b1;
    sendChar(K_SOP, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 3) expShort.push_back({1'b0, 1'b0, (i == 1), 8'(i)});
      else if (i == 4) expShort.push_back({1'b1, 1'b1, 1'b0, 8'(i)});
      sendChar(K_DATA, 8'(i));
    end
    sendChar(K_EOP, 8'h00);
    idle(6);
    checks++; if (obsShort.size() != expShort.size()) begin fails++; $display("[TB] FAIL maxlen_count: got %0d expected %0d", obsShort.size(), expShort.size()); end
    while (expShort.size() > 0 && obsShort.size() > 0) begin
      e = expShort.pop_front(); o = obsShort.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL maxlen_entry: got %h expected %h", o, e); end
    end
    checks++; if (shortErrCnt !== 8'd1) begin fails++; $display("[TB] FAIL maxlen_err_cnt: got %0d expected 1", shortErrCnt); end
    checks++; if (shortFrameCnt !== 16'd0) begin fails++; $display("[TB] FAIL maxlen_frame_cnt: got %0d expected 0", shortFrameCnt); end
    // Back in IDLE a stray data byte counts as an error and writes nothing.
    obsShort.delete();
    sendChar(K_DATA, 8'h77);
    idle(4);
    checks++; if (shortErrCnt !== 8'd2) begin fails++; $display("[TB] FAIL maxlen_idle_err: got %0d expected 2", shortErrCnt); end
    checks++; if (obsShort.size() != 0) begin fails++; $display("[TB] FAIL maxlen_idle_write: got %0d expected 0", obsShort.size()); end
  endtask

  task automatic test_fifo_full();
    logic [10:0] e, o;
    applyReset();
    frame_ready = 1'b0;
    sendChar(K_SOP, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) expMain.push_back({1'b0, 1'b0, (i == 0), 8'h40 + 8'(i)});
      else if (i == 4) expMain.push_back({1'b1, 1'b1, 1'b0, 8'h44});
      sendChar(K_DATA, 8'h40 + 8'(i));
    end
    sendChar(K_EOP, 8'h00);
    idle(3);
    checks++; if ({mainValid, mainFirst, mainData} !== {1'b1, 1'b1, 8'h40}) begin fails++; $display("[TB] FAIL full_head: got %b/%b/%h expected 1/1/40", mainValid, mainFirst, mainData); end
    idle(3);
    checks++; if ({mainValid, mainData} !== {1'b1, 8'h40}) begin fails++; $display("[TB] FAIL full_head_stable: got %b/%h expected 1/40", mainValid, mainData); end
    frame_ready = 1'b1;
    idle(12);
    checks++; if (obsMain.size() != expMain.size()) begin fails++; $display("[TB] FAIL full_count: got %0d expected %0d", obsMain.size(), expMain.size()); end
    while (expMain.size() > 0 && obsMain.size() > 0) begin
      e = expMain.pop_front(); o = obsMain.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL full_entry: got %h expected %h", o, e); end
    end
    checks++; if (mainErrCnt !== 8'd1) begin fails++; $display("[TB] FAIL full_err_cnt: got %0d expected 1", mainErrCnt); end
    checks++; if (mainFrameCnt !== 16'd0) begin fails++; $display("[TB] FAIL full_frame_cnt: got %0d expected 0", mainFrameCnt); end
  endtask

  task automatic test_commas();
    logic [10:0] e, o;
    applyReset();
    frame_ready = 1'b1;
    sendChar(K_COMMA, 8'hBC);
    sendChar(K_DATA, 8'h55);
    sendChar(K_COMMA, 8'hBC);
    sendChar(K_EOP, 8'h00);
    sendChar(K_COMMA, 8'hBC);
    idle(4);
    checks++; if (obsMain.size() != 0) begin fails++; $display("[TB] FAIL idle_writes: got %0d expected 0", obsMain.size()); end
    checks++; if (mainErrCnt !== 8'd2) begin fails++; $display("[TB] FAIL idle_err_cnt: got %0d expected 2", mainErrCnt); end
    repeat (3) sendChar(K_COMMA, 8'hBC);
    idle(3);
    checks++; if ({mainValid, mainErrCnt, mainFrameCnt} !== {1'b0, 8'd2, 16'd0}) begin fails++; $display("[TB] FAIL comma_only: got %b/%0d/%0d expected 0/2/0", mainValid, mainErrCnt, mainFrameCnt); end
    sendChar(K_SOP, 8'h00);
    sendChar(K_COMMA, 8'hBC);
    expMain.push_back({1'b0, 1'b0, 1'b1, 8'h10}); sendChar(K_DATA, 8'h10);
    sendChar(K_COMMA, 8'hBC);
    expMain.push_back({1'b0, 1'b1, 1'b0, 8'h20}); sendChar(K_DATA, 8'h20);
    sendChar(K_COMMA, 8'hBC);
    sendChar(K_EOP, 8'h00);
    idle(6);
    checks++; if (obsMain.size() != expMain.size()) begin fails++; $display("[TB] FAIL comma_frame_count: got %0d expected %0d", obsMain.size(), expMain.size()); end
    while (expMain.size() > 0 && obsMain.size() > 0) begin
      e = expMain.pop_front(); o = obsMain.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL comma_frame_entry: got %h expected %h", o, e); end
    end
    checks++; if (mainFrameCnt !== 16'd1) begin fails++; $display("[TB] FAIL comma_frame_cnt: got %0d expected 1", mainFrameCnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] e, o;
    applyReset();
    frame_ready = 1'b0;
    sendChar(K_DATA, 8'h99);
    sendChar(K_SOP, 8'h00);
    sendChar(K_DATA, 8'h01);
    sendChar(K_DATA, 8'h02);
    idle(2);
    checks++; if ({mainValid, mainErrCnt} !== {1'b1, 8'd1}) begin fails++; $display("[TB] FAIL premid_state: got %b/%0d expected 1/1", mainValid, mainErrCnt); end
    rst_n = 1'b0;
    idle(2);
    checks++; if (mainValid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", mainValid); end
    checks++; if ({mainErrCnt, mainFrameCnt} !== 24'd0) begin fails++; $display("[TB] FAIL mid_reset_cnts: got %0d/%0d expected 0/0", mainErrCnt, mainFrameCnt); end
    rst_n = 1'b1;
    idle(1);
    obsMain.delete();
    frame_ready = 1'b1;
    sendChar(K_SOP, 8'h00);
    expMain.push_back({1'b0, 1'b1, 1'b1, 8'h03}); sendChar(K_DATA, 8'h03);
    sendChar(K_EOP, 8'h00);
    idle(6);
    checks++; if (obsMain.size() != expMain.size()) begin fails++; $display("[TB] FAIL mid_after_count: got %0d expected %0d", obsMain.size(), expMain.size()); end
    while (expMain.size() > 0 && obsMain.size() > 0) begin
      e = expMain.pop_front(); o = obsMain.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL mid_after_entry: got %h expected %h", o, e); end
    end
    checks++; if (mainFrameCnt !== 16'd1) begin fails++; $display("[TB] FAIL mid_after_frame_cnt: got %0d expected 1", mainFrameCnt); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e, o;
    applyReset();
    randReady = 1'b1;
    sendChar(K_SOP, 8'h00);
    expMain.push_back({1'b0, 1'b0, 1'b1, 8'hA1}); sendChar(K_DATA, 8'hA1);
    expMain.push_back({1'b0, 1'b1, 1'b0, 8'hA2}); sendChar(K_DATA, 8'hA2);
    sendChar(K_EOP, 8'h00);
    sendChar(K_SOP, 8'h00);
    expMain.push_back({1'b0, 1'b1, 1'b1, 8'hB1}); sendChar(K_DATA, 8'hB1);
    sendChar(K_EOP, 8'h00);
    idle(8);
    randReady = 1'b0;
    frame_ready = 1'b1;
    idle(6);
    checks++; if (obsMain.size() != expMain.size()) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected %0d", obsMain.size(), expMain.size()); end
    while (expMain.size() > 0 && obsMain.size() > 0) begin
      e = expMain.pop_front(); o = obsMain.pop_front();
      checks++; if (o !== e) begin fails++; $display("[TB] FAIL b2b_entry: got %h expected %h", o, e); end
    end
    checks++; if ({mainFrameCnt, mainErrCnt} !== {16'd2, 8'd0}) begin fails++; $display("[TB] FAIL b2b_cnts: got %0d/%0d expected 2/0", mainFrameCnt, mainErrCnt); end
  endtask

  initial begin
    rst_n       = 1'b0;
    DATA_RDY    = 1'b0;
    HGFEDCBA    = 8'h00;
    ISK         = K_COMMA;
    frame_ready = 1'b0;
    randReady   = 1'b0;
    @(posedge bitCLKx4);
    #1;
    $display("[TB] starting elink_in_frame_assembler bench");
    test_reset();
    test_basic_frame();
    test_sop_abort();
    test_max_len();
    test_fifo_full();
    test_commas();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
